// File: rtl/epp_host_if.sv
// epp_host_if: command/response handshake between internal logic and the EPP host
interface epp_host_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_is_addr;
  logic       cmd_read;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_timeout;
  logic       busy;
  modport master (
    output cmd_valid, cmd_is_addr, cmd_read, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_timeout, busy
  );
  modport slave (
    input  cmd_valid, cmd_is_addr, cmd_read, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_timeout, busy
  );
endinterface

// File: rtl/epp_host.sv
// epp_host: EPP host that turns single-byte commands into Astb/Dstb bus cycles closed on Wait.
// Optional per-phase abort timer enabled by defining EPP_TIMEOUT_EN.
module epp_host #(
  parameter int SETUP_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  epp_host_if.slave  cmd,
  inout  wire  [7:0] Db,
  output logic       Astb,
  output logic       Dstb,
  output logic       Wr,
  input  logic       Wait
);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETUP   = 3'd1;
  localparam logic [2:0] S_STROBE  = 3'd2;
  localparam logic [2:0] S_RELEASE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;
  localparam int SW = SETUP_CYCLES > 1 ? $clog2(SETUP_CYCLES) : 1;

  logic [2:0]                  state, nxt;
  logic [SW-1:0]               setup_cnt;
  logic                        setup_done;
  logic                        is_addr, rd, drive;
  logic [7:0]                  wdata;
  logic [SYNC_STAGES-1:0]      wait_sr;
  logic [SYNC_STAGES-1:0][7:0] db_sr;
  logic                        wait_s;
  logic [7:0]                  db_s;
  logic                        abort, phase_end;

  assign wait_s        = wait_sr[SYNC_STAGES-1];
  assign db_s          = db_sr[SYNC_STAGES-1];
  assign Db            = drive ? wdata : 8'bz;
  assign cmd.cmd_ready = state == S_IDLE;
  assign cmd.busy      = state != S_IDLE;
  assign setup_done    = setup_cnt == SW'(SETUP_CYCLES - 1);

  // Wait and Db come from another clock domain; shift them through a synchronizer chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_sr <= '0;
      db_sr   <= '0;
    end else begin
      wait_sr <= {wait_sr[SYNC_STAGES-2:0], Wait};
      db_sr   <= {db_sr[SYNC_STAGES-2:0], Db};
    end
  end

`ifdef EPP_TIMEOUT_EN
  logic [15:0] phase_cnt;
  assign phase_end = phase_cnt == 16'(TIMEOUT_CYCLES - 1);
  // Phase timer restarts on every entry into STROBE or RELEASE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) phase_cnt <= '0;
    else phase_cnt <= (nxt == state && (state == S_STROBE || state == S_RELEASE)) ? phase_cnt + 1'b1 : 16'd0;
  end
  // Abort flag marks a strobe phase that ran out without seeing Wait
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) abort <= 1'b0;
    else if (state == S_IDLE) abort <= 1'b0;
    else if (state == S_STROBE && !wait_s && phase_end) abort <= 1'b1;
  end
`else
  logic unused_timeout;
  assign phase_end      = 1'b0;
  assign abort          = 1'b0;
  assign unused_timeout = |TIMEOUT_CYCLES;
`endif

  // Next-state decode; a timer expiry leaves a phase exactly like a handshake edge would
  always_comb begin
    nxt = state == S_IDLE    ? (cmd.cmd_valid ? S_SETUP : S_IDLE) :
          state == S_SETUP   ? (setup_done ? S_STROBE : S_SETUP) :
          state == S_STROBE  ? (wait_s || phase_end ? S_RELEASE : S_STROBE) :
          state == S_RELEASE ? (!wait_s || phase_end ? S_DONE : S_RELEASE) : S_IDLE;
  end

  // Cycle sequencing; strobes are registered from nxt so only one can ever be low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      setup_cnt       <= '0;
      is_addr         <= 1'b0;
      rd              <= 1'b0;
      wdata           <= 8'h00;
      drive           <= 1'b0;
      Astb            <= 1'b1;
      Dstb            <= 1'b1;
      Wr              <= 1'b1;
      cmd.rsp_valid   <= 1'b0;
      cmd.rsp_rdata   <= 8'h00;
      cmd.rsp_timeout <= 1'b0;
    end else begin
      state           <= nxt;
      setup_cnt       <= state == S_SETUP ? setup_cnt + 1'b1 : '0;
      Astb            <= !(nxt == S_STROBE && is_addr);
      Dstb            <= !(nxt == S_STROBE && !is_addr);
      cmd.rsp_valid   <= state == S_RELEASE && nxt == S_DONE;
      cmd.rsp_timeout <= state == S_RELEASE && nxt == S_DONE && abort;
      if (state == S_IDLE && cmd.cmd_valid) begin
        is_addr       <= cmd.cmd_is_addr;
        rd            <= cmd.cmd_read;
        wdata         <= cmd.cmd_wdata;
        Wr            <= cmd.cmd_read;
        drive         <= !cmd.cmd_read;
        cmd.rsp_rdata <= 8'h00;
      end
      if (state == S_STROBE && wait_s && rd) cmd.rsp_rdata <= db_s;
      if (state == S_RELEASE && nxt == S_DONE) begin
        Wr    <= 1'b1;
        drive <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_epp_host.sv
// tb_epp_host: directed bench for epp_host with a peripheral model and a per-cycle bus scoreboard
module tb_epp_host;
  localparam int SETUP = 2;
  localparam int TO    = 16;
  localparam int SYNC  = 2;

  typedef struct {
    bit         is_addr;
    bit         rd;
    bit         to;
    logic [7:0] wdata;
    logic [7:0] rdata;
    int         acc;
  } cyc_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  wire  [7:0] Db;
  logic       Astb, Dstb, Wr;
  logic       Wait;
  logic       per_drv = 1'b0;
  logic [7:0] per_data = 8'h00;
  bit         tie_low = 1'b0;
  int         per_delay = 3;
  bit         exp_to = 1'b0;
  int         total = 0;
  int         bad = 0;
  int         astb_falls = 0;
  int         dstb_falls = 0;
  int         rsp_cnt = 0;
  cyc_t       q[$];

  always #5 clk = ~clk;

  assign Db = per_drv ? per_data : 8'bz;

  epp_host_if bus();

  epp_host #(.SETUP_CYCLES(SETUP), .TIMEOUT_CYCLES(TO), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .cmd(bus), .Db(Db),
    .Astb(Astb), .Dstb(Dstb), .Wr(Wr), .Wait(Wait)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Peripheral: drives read data while strobed, raises Wait per_delay clocks into the strobe
  initial begin
    int cnt;
    cnt = 0;
    Wait = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (!Astb || !Dstb) begin
        cnt++;
        per_drv = Wr;
        if (!tie_low && cnt >= per_delay) Wait = 1'b1;
      end else begin
        cnt = 0;
        Wait = 1'b0;
        per_drv = 1'b0;
      end
    end
  end

  // Scoreboard: checks every cycle against the bus rules and the queue of accepted commands
  initial begin
    int         cyc;
    int         low_len;
    logic       pa, pd, pwr;
    logic [7:0] pdb;
    cyc_t       e;
    cyc = 0; low_len = 0; pa = 1'b1; pd = 1'b1; pwr = 1'b1; pdb = 8'h00;
    forever begin
      @(negedge clk);
      cyc++;
      chk("no_overlap", int'(!Astb && !Dstb), 0);
      chk("busy", int'(bus.busy), int'(!bus.cmd_ready));
      if (!rst_n) begin
        chk("rst_astb", int'(Astb), 1);
        chk("rst_dstb", int'(Dstb), 1);
        chk("rst_wr", int'(Wr), 1);
        chk("rst_ready", int'(bus.cmd_ready), 1);
        chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
        chk("rst_rdata", int'(bus.rsp_rdata), 0);
        q.delete();
        low_len = 0;
      end else begin
        if (Wr !== pwr || (!Wr && !pwr && Db !== pdb))
          chk("wr_db_change_strobes_high", int'(pa && pd && Astb && Dstb), 1);
        if (pa && pd && (!Astb || !Dstb)) begin
          if (!Astb) astb_falls++;
          else dstb_falls++;
          if (q.size() == 0) chk("strobe_without_cmd", 1, 0);
          else begin
            chk("strobe_sel", int'(!Astb), int'(q[0].is_addr));
            chk("setup_time", cyc - q[0].acc, SETUP + 1);
            chk("wr_dir", int'(Wr), int'(q[0].rd));
            if (!q[0].rd) chk("db_wdata", int'(Db), int'(q[0].wdata));
          end
        end
        if (!Astb || !Dstb) low_len++;
        else begin
          if (low_len > 0 && q.size() > 0 && q[0].to) chk("timeout_low_len", low_len, TO);
          low_len = 0;
        end
        if (bus.rsp_valid) begin
          rsp_cnt++;
          if (q.size() == 0) chk("rsp_without_cmd", 1, 0);
          else begin
            e = q.pop_front();
            chk("rsp_rdata", int'(bus.rsp_rdata), (e.rd && !e.to) ? int'(e.rdata) : 0);
            chk("rsp_timeout", int'(bus.rsp_timeout), int'(e.to));
            chk("rsp_strobes_high", int'(Astb && Dstb), 1);
          end
        end
        if (bus.cmd_valid && bus.cmd_ready) begin
          chk("one_outstanding", q.size(), 0);
          chk("wait_low_at_accept", int'(Wait), 0);
          q.push_back('{bus.cmd_is_addr, bus.cmd_read, exp_to, bus.cmd_wdata, per_data, cyc});
        end
      end
      pa = Astb; pd = Dstb; pwr = Wr; pdb = Db;
    end
  end

  task automatic send(input bit a, input bit r, input logic [7:0] d);
    bus.cmd_is_addr = a;
    bus.cmd_read    = r;
    bus.cmd_wdata   = d;
    bus.cmd_valid   = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    chk("accept_wait_expired", 0, 1);
  endtask

  task automatic wait_rsp(output logic [7:0] d, output bit t);
    d = 8'h00;
    t = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        d = bus.rsp_rdata;
        t = bus.rsp_timeout;
        @(posedge clk);
        #1;
        return;
      end
    end
    chk("rsp_wait_expired", 0, 1);
  endtask

  initial begin
    logic [7:0] d;
    bit         t;
    int         a0, d0, r0;
    bit         seen;
    bus.cmd_valid = 1'b0; bus.cmd_is_addr = 1'b0; bus.cmd_read = 1'b0; bus.cmd_wdata = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", int'(bus.cmd_ready), 1);
    chk("idle_astb", int'(Astb), 1);
    @(posedge clk);
    #1;

    a0 = astb_falls; d0 = dstb_falls; r0 = rsp_cnt;
    send(1'b0, 1'b0, 8'hA5);
    bus.cmd_valid = 1'b0;
    wait_rsp(d, t);
    chk("t2_timeout", int'(t), 0);
    chk("t2_rdata", int'(d), 8'h00);
    chk("t2_astb_pulses", astb_falls - a0, 0);
    chk("t2_dstb_pulses", dstb_falls - d0, 1);
    chk("t2_rsp_count", rsp_cnt - r0, 1);

    a0 = astb_falls; d0 = dstb_falls;
    per_data = 8'h3C;
    send(1'b1, 1'b1, 8'h00);
    bus.cmd_valid = 1'b0;
    wait_rsp(d, t);
    chk("t3_rdata", int'(d), 8'h3C);
    chk("t3_timeout", int'(t), 0);
    chk("t3_astb_pulses", astb_falls - a0, 1);
    chk("t3_dstb_pulses", dstb_falls - d0, 0);

    per_data = 8'h5A; per_delay = 1;
    send(1'b0, 1'b1, 8'hFF);
    bus.cmd_valid = 1'b0;
    wait_rsp(d, t);
    chk("data_read_rdata", int'(d), 8'h5A);

    per_delay = 6;
    send(1'b1, 1'b0, 8'h77);
    bus.cmd_valid = 1'b0;
    wait_rsp(d, t);
    chk("addr_write_rdata", int'(d), 8'h00);
    per_delay = 3;

`ifdef EPP_TIMEOUT_EN
    exp_to = 1'b1; tie_low = 1'b1; per_data = 8'hC3;
    send(1'b0, 1'b1, 8'h00);
    bus.cmd_valid = 1'b0;
    wait_rsp(d, t);
    chk("t4_timeout", int'(t), 1);
    chk("t4_rdata", int'(d), 8'h00);
    exp_to = 1'b0; tie_low = 1'b0;
`endif

    d0 = dstb_falls; r0 = rsp_cnt;
    send(1'b0, 1'b0, 8'h11);
    send(1'b0, 1'b0, 8'h22);
    bus.cmd_valid = 1'b0;
    wait_rsp(d, t);
    chk("t5_rsp_count", rsp_cnt - r0, 2);
    chk("t5_dstb_pulses", dstb_falls - d0, 2);

    send(1'b0, 1'b0, 8'h99);
    bus.cmd_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(posedge clk);
      #1;
      seen = !Dstb;
    end
    chk("t6_strobe_seen", int'(seen), 1);
    r0 = rsp_cnt;
    #1 rst_n = 1'b0;
    #1;
    chk("t6_dstb_async", int'(Dstb), 1);
    chk("t6_wr_async", int'(Wr), 1);
    chk("t6_astb_async", int'(Astb), 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("t6_no_rsp", rsp_cnt - r0, 0);
    send(1'b0, 1'b0, 8'h42);
    bus.cmd_valid = 1'b0;
    wait_rsp(d, t);
    chk("t6_after_rsp_count", rsp_cnt - r0, 1);
    chk("t6_after_timeout", int'(t), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end
endmodule
